// File: rtl/timer_pkg.sv
// Shared constants for the mm:ss countdown timer: state encoding, counter width, seconds limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] SEC_MAX = 8'd59;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Saturate a loaded preset to its legal maximum.
    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/counter60_down.sv
// Mod-60 down-counter with synchronous load; borrow pulses on the 0 -> 59 wrap.
// Latency: one clk from en/ld to count_num/borrow.
// Backpressure: none; en is a qualified enable, ld has priority over en.
//
// Ports: clk, RESET (sync, active-high), en (count down one step), ld (load ld_val,
//        clamped to 59), ld_val; count_num (0..59), borrow (one-cycle wrap pulse).
module counter60_down
    import timer_pkg::*;
(
    input  logic             clk,
    input  logic             RESET,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] count_num,
    output logic             borrow
);

    always_ff @(posedge clk) begin
        if (RESET) begin
            count_num <= '0;
            borrow    <= 1'b0;
        end else begin
            borrow <= 1'b0;
            if (ld) begin
                count_num <= clamp(ld_val, SEC_MAX);
            end else if (en) begin
                if (count_num == '0) begin
                    count_num <= SEC_MAX;
                    borrow    <= 1'b1;
                end else begin
                    count_num <= count_num - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/countdown_mmss.sv
// Minutes:seconds countdown timer with start/stop/load control and a timed alarm after expiry.
// Latency: all outputs registered; one clk from any input pulse to its effect.
// Backpressure: none; control pulses are single-cycle, priority RESET > stop > load > start > tick.
//
// Ports: clk, RESET (sync, active-high), tick (1 Hz enable), start/stop/load (one-cycle pulses),
//        load_min/load_sec (binary presets); min_num, sec_num (current value), sec_borrow
//        (seconds wrap pulse), running (state is RUN), done (expiry pulse), alarm (level in DONE).
module countdown_mmss
    import timer_pkg::*;
#(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 10
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [CNT_W-1:0] load_min,
    input  logic [CNT_W-1:0] load_sec,
    output logic [CNT_W-1:0] min_num,
    output logic [CNT_W-1:0] sec_num,
    output logic             sec_borrow,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] MIN_LIM   = CNT_W'(MAX_MIN);
    localparam logic [CNT_W-1:0] ALM_LAST  = CNT_W'(ALARM_TICKS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] alarm_cnt;
    logic [CNT_W-1:0] alarm_cnt_d;
    logic             running_d;
    logic             done_d;
    logic             alarm_d;

    logic             is_zero;
    logic             last_sec;
    logic             load_acc;
    logic             count_en;
    logic             min_en;

    // Event decode shared by the counters and the FSM.
    assign is_zero  = (min_num == '0) && (sec_num == '0);
    assign last_sec = (min_num == '0) && (sec_num == 8'd1);
    // stop outranks load everywhere, and load is ignored while counting.
    assign load_acc = load && !stop && (state_q != ST_RUN);
    assign count_en = (state_q == ST_RUN) && tick && !stop;
    // Minutes step on the same edge the seconds wrap, so the wrap is decoded here
    // from the current seconds value rather than from the registered borrow.
    assign min_en   = count_en && (sec_num == '0) && (min_num != '0);

    counter60_down u_sec (
        .clk       (clk),
        .RESET     (RESET),
        .en        (count_en),
        .ld        (load_acc),
        .ld_val    (load_sec),
        .count_num (sec_num),
        .borrow    (sec_borrow)
    );

    // Saturating minutes register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            min_num <= '0;
        end else if (load_acc) begin
            min_num <= clamp(load_min, MIN_LIM);
        end else if (min_en) begin
            min_num <= min_num - 1'b1;
        end
    end

    // State and registered FSM outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state_q   <= state_d;
            running   <= running_d;
            done      <= done_d;
            alarm     <= alarm_d;
            alarm_cnt <= alarm_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                // A stop pulse here does nothing but still suppresses load/start.
                if (!stop) begin
                    if (load) begin
                        state_d = ST_IDLE;
                    end else if (start && !is_zero) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (tick && last_sec) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (stop || load || start) begin
                    state_d = ST_IDLE;
                end else if (tick && (alarm_cnt == ALM_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: outputs are a registered image of the next state.
    always_comb begin
        running_d   = (state_d == ST_RUN);
        alarm_d     = (state_d == ST_DONE);
        done_d      = (state_q == ST_RUN) && (state_d == ST_DONE);
        alarm_cnt_d = '0;
        if ((state_q == ST_DONE) && (state_d == ST_DONE) && tick) begin
            alarm_cnt_d = alarm_cnt + 1'b1;
        end else if (state_q == ST_DONE) begin
            alarm_cnt_d = alarm_cnt;
        end
    end

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: per-scenario tasks queue stimulus with expected outputs.
// Latency: expected values compared 1 time unit after the edge that applied the stimulus.
// Backpressure: n/a.
module tb_countdown_mmss;

    logic       clk = 1'b0;
    logic       RESET, tick, start, stop, load;
    logic [7:0] load_min, load_sec;
    logic [7:0] min_num, sec_num;
    logic       sec_borrow, running, done, alarm;

    countdown_mmss #(.MAX_MIN(99), .ALARM_TICKS(10)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .min_num    (min_num),
        .sec_num    (sec_num),
        .sec_borrow (sec_borrow),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] s;
        logic       b;
        logic       r;
        logic       d;
        logic       a;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       t;
        logic       st;
        logic       sp;
        logic       ld;
        logic [7:0] lm;
        logic [7:0] ls;
    } stim_t;

    stim_t plan_s[$];
    obs_t  plan_e[$];
    obs_t  exp_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic obs_t E(input int m, input int s, input logic b, input logic r,
                               input logic d, input logic a);
        obs_t o;
        o.m = 8'(m);
        o.s = 8'(s);
        o.b = b;
        o.r = r;
        o.d = d;
        o.a = a;
        return o;
    endfunction

    function automatic stim_t S(input logic rst, input logic t, input logic st, input logic sp,
                                input logic ld, input int lm = 0, input int ls = 0);
        stim_t x;
        x.rst = rst;
        x.t   = t;
        x.st  = st;
        x.sp  = sp;
        x.ld  = ld;
        x.lm  = 8'(lm);
        x.ls  = 8'(ls);
        return x;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {min_num, sec_num, sec_borrow, running, done, alarm};
        return o;
    endfunction

    task automatic plan(input stim_t x, input obs_t e);
        plan_s.push_back(x);
        plan_e.push_back(e);
    endtask

    task automatic apply(input stim_t x);
        RESET    = x.rst;
        tick     = x.t;
        start    = x.st;
        stop     = x.sp;
        load     = x.ld;
        load_min = x.lm;
        load_sec = x.ls;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(1, 1, 1, 0, 1, 5, 5), E(0, 0, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL reset[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_expiry();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 3), E(0, 3, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 3, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 2, 0, 1, 0, 0));
        plan(S(0, 0, 0, 0, 0), E(0, 2, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 1, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 1, 1));
        plan(S(0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 1));
        for (int k = 1; k <= 9; k++) plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 1));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL expiry[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_borrow();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 2, 0), E(2, 0, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(2, 0, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(1, 59, 1, 1, 0, 0));
        plan(S(0, 0, 0, 0, 0), E(1, 59, 0, 1, 0, 0));
        for (int k = 1; k <= 59; k++) plan(S(0, 1, 0, 0, 0), E(1, 59 - k, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 59, 1, 1, 0, 0));
        plan(S(0, 0, 0, 1, 0), E(0, 59, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 59, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL borrow[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 150, 75), E(99, 59, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 99, 59), E(99, 59, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 60), E(0, 59, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 100, 0), E(99, 0, 0, 0, 0, 0));
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL clamp[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 10), E(0, 10, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 10, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 9, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 8, 0, 1, 0, 0));
        plan(S(0, 1, 0, 1, 0), E(0, 8, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) plan(S(0, 1, 0, 0, 0), E(0, 8, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 8, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 7, 0, 1, 0, 0));
        plan(S(0, 0, 0, 1, 0), E(0, 7, 0, 0, 0, 0));
        plan(S(0, 0, 1, 1, 0), E(0, 7, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 7, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL pause[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_load_in_run();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 1, 30), E(1, 30, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(1, 30, 0, 1, 0, 0));
        plan(S(0, 0, 0, 0, 1, 5, 0), E(1, 30, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 1, 5, 0), E(1, 29, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(1, 28, 0, 1, 0, 0));
        plan(S(1, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL load_in_run[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    task automatic test_done_clear();
        obs_t e, o;
        plan(S(1, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 1), E(0, 1, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 1, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 1, 1));
        plan(S(0, 0, 1, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 1), E(0, 1, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 1, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 1, 1));
        plan(S(0, 0, 0, 1, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 1, 0, 1), E(0, 1, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 1, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(0, 0, 0, 0, 1, 1));
        plan(S(0, 0, 0, 0, 1, 0, 2), E(0, 2, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(0, 2, 0, 1, 0, 0));
        plan(S(0, 0, 0, 1, 0), E(0, 2, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 1, 3, 20), E(3, 20, 0, 0, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(3, 20, 0, 0, 0, 0));
        plan(S(0, 0, 1, 0, 0), E(3, 20, 0, 1, 0, 0));
        plan(S(0, 1, 0, 0, 0), E(3, 19, 0, 1, 0, 0));
        for (int i = 0; plan_s.size() > 0; i++) begin
            exp_q.push_back(plan_e.pop_front());
            apply(plan_s.pop_front());
            e = exp_q.pop_front();
            o = observe();
            n_total++;
            if (o !== e)
                $display("FAIL done_clear[%0d] got %0d:%0d b%b r%b d%b a%b want %0d:%0d b%b r%b d%b a%b",
                         i, o.m, o.s, o.b, o.r, o.d, o.a, e.m, e.s, e.b, e.r, e.d, e.a);
            else n_pass++;
        end
    endtask

    initial begin
        RESET    = 1'b0;
        tick     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        load     = 1'b0;
        load_min = 8'd0;
        load_sec = 8'd0;
        test_reset();
        test_expiry();
        test_borrow();
        test_clamp();
        test_pause();
        test_load_in_run();
        test_done_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
- Minutes:seconds countdown timer for the watch; the down-counting counterpart of the mod-60 up-counter/carry chain.
- Built from two mod-60-style down-counters chained by a borrow instead of a carry.
- Driven by a 1 Hz tick enable; outputs feed the display mux and the alarm/buzzer driver.
- Fully synchronous in one clock domain. No derived or gated clocks.

Parameters:
- MAX_MIN, 99, maximum loadable minutes value (1..99).
- ALARM_TICKS, 10, number of ticks the alarm output stays high after expiry (1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle 1 Hz enable pulse.
- start  input  1  one-cycle pulse; start or resume the countdown.
- stop  input  1  one-cycle pulse; pause the countdown.
- load  input  1  one-cycle pulse; load the preset value.
- load_min  input  8  preset minutes, binary.
- load_sec  input  8  preset seconds, binary.
- min_num  output  8  current minutes, binary, 0..MAX_MIN.
- sec_num  output  8  current seconds, binary, 0..59.
- sec_borrow  output  1  one-cycle pulse when seconds wrap from 0 to 59.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse on expiry.
- alarm  output  1  level; high in DONE until cleared.

Behaviour:
- Reset: RESET sampled high at a rising edge gives state=IDLE, min_num=0, sec_num=0, sec_borrow=0, running=0, done=0, alarm=0, alarm counter=0. Reset mid-countdown aborts immediately and takes priority over all other inputs.
- All outputs are registered and change only on a clk rising edge.
- States: IDLE, RUN, PAUSE, DONE. Encoding is a localparam from the shared package.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - sec_num <= min(load_sec, 59); min_num <= min(load_min, MAX_MIN).
  - Next state is IDLE; alarm cleared.
- Start:
  - From IDLE or PAUSE: go to RUN only if {min_num, sec_num} != 0:00; otherwise ignored.
  - From DONE: alarm cleared, go to IDLE, no count change.
- Stop: RUN -> PAUSE. Ignored in IDLE and PAUSE. In DONE it clears alarm and goes to IDLE.
- RUN, on a cycle with tick=1:
  - If sec_num > 0: sec_num-1.
  - Else if min_num > 0: sec_num <= 59, min_num-1, sec_borrow=1 for that cycle.
  - Values reach 0:00 on the tick that decrements 0:01.
  - At that same edge: state <= DONE, done=1 for one cycle, alarm=1, alarm counter=0.
- RUN with tick=0: no change.
- DONE:
  - Each tick increments the alarm counter.
  - When the counter reaches ALARM_TICKS, alarm <= 0 and state <= IDLE.
  - Counts hold at 0:00.
- Simultaneous events, priority order RESET > stop > load > start > tick:
  - stop+tick in RUN: pause, no decrement.
  - start+stop in the same cycle: stop wins. From PAUSE this means no change.
  - load+start in IDLE or PAUSE: load only; start is dropped and a new start pulse is required.
  - tick in IDLE or PAUSE: no effect.
- sec_borrow is never asserted outside RUN. It is never asserted on the expiry tick, since seconds do not wrap there.
- running = (state == RUN), registered with the state.

Decomposition:
- Shared package (timer_pkg):
  - state localparams ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - SEC_MAX = 59.
  - Counter width constant CNT_W = 8.
- Sub-module counter60_down: mod-60 down-counter.
  - Inputs: clk, RESET, en, ld, ld_val.
  - Outputs: count_num, borrow. borrow is a one-cycle pulse on the 0 -> 59 wrap.
  - Instantiated for seconds.
- Minutes use a plain saturating down-register in the top level, enabled by the seconds borrow and loaded with the clamped value.
- The FSM and alarm counter live in the top level.

Test Plan:
- Reset, load 0:03, start, 3 ticks: sec_num 2,1,0. On the 3rd tick edge done pulses once, alarm=1. After 10 more ticks alarm=0 and state is IDLE.
- Load 2:00, start, 1 tick: min_num=1, sec_num=59, sec_borrow high exactly that cycle. Next 59 ticks produce no borrow.
- Load min=150, sec=75 with MAX_MIN=99: min_num=99, sec_num=59. Start at 0:00 after a reset: stays IDLE, running=0.
- Load 0:10, start, 2 ticks, then stop asserted together with a tick: value holds 0:08 in PAUSE. 5 ticks: no change. Start, 1 tick: 0:07.
- In RUN at 1:30, pulse load with 5:00: ignored, count continues. RESET asserted mid-run: next edge all outputs 0, state IDLE.
- Alarm active in DONE, pulse start: alarm=0 next edge, state IDLE, counts 0:00. Load+start in the same cycle from PAUSE: value loaded, running=0.
